// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo write-port arbiter: FSM encodings and default sizes.
// Optional round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN.
package fifo_wr_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_CHECK = 3'd2
    } arb_state_e;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_DW    = 32;

    function automatic int unsigned idx_width(int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: first requesting index at or after base, wrapping upward.
// Tying base to zero gives fixed lowest-index priority.
module arb_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IW    = idx_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    base,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    idx
);

    logic        found;
    int unsigned pos;

    always_comb begin
        found  = 1'b0;
        pos    = 0;
        idx    = '0;
        winner = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(base) + k) % N_REQ;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
        if (found) begin
            winner[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates N_REQ requesters onto the single fifo write port, one write per three cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise the lowest requesting index wins.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [N_REQ-1:0]    err,
    output logic                busy,
    output logic                fifo_wr_en,
    output logic [DW-1:0]       fifo_din,
    input  logic                fifo_full,
    input  logic                fifo_wr_ack,
    input  logic                fifo_wr_err
);

    localparam int unsigned IW = idx_width(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    base;
    logic [N_REQ-1:0] pick_onehot;
    logic [N_REQ-1:0] gnt_q;
    logic             wr_en_q;
    logic [DW-1:0]    din_q;
    logic [DW-1:0]    sel_data;
    logic             grant;

    // fifo_full is trustworthy here because this block is the fifo's only writer.
    assign grant = (state_q == ST_IDLE) && (|req) && !fifo_full;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (grant) begin
            ptr_q <= (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IW'(1);
        end
    end

    assign base = ptr_q;
`else
    assign base = '0;
`endif

    arb_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .base   (base),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(pick_idx) == i) begin
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_CHECK;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = '0;
        err  = '0;
        if (state_q == ST_CHECK) begin
            done[idx_q] = fifo_wr_ack;
            err[idx_q]  = fifo_wr_err;
        end
    end

    // Grant, index and data are captured together at the grant decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            gnt_q   <= '0;
            wr_en_q <= 1'b0;
            din_q   <= '0;
        end else if (grant) begin
            idx_q   <= pick_idx;
            gnt_q   <= pick_onehot;
            wr_en_q <= 1'b1;
            din_q   <= sel_data;
        end else begin
            wr_en_q <= 1'b0;
            if (state_q == ST_CHECK) begin
                gnt_q <= '0;
            end
        end
    end

    assign gnt        = gnt_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a behavioural 8-deep fifo model.
// Expectations follow ARB_ROUND_ROBIN_EN the same way the design does.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 300;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt, done, err;
    logic            busy, fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            fifo_full;
    logic            fifo_wr_ack = 1'b0;
    logic            fifo_wr_err = 1'b0;

    int   fcount   = 0;
    logic rd       = 1'b0;
    logic inj      = 1'b0;
    logic fifo_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [N-1:0]  eg [0:L+3];
    logic [N-1:0]  ed [0:L+3];
    logic [N-1:0]  ee [0:L+3];
    logic          ew [0:L+3];
    logic          eb [0:L+3];
    logic [DW-1:0] ex [0:L+3];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ (N),
        .DW    (DW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .fifo_full   (fifo_full),
        .fifo_wr_ack (fifo_wr_ack),
        .fifo_wr_err (fifo_wr_err)
    );

    // Fifo model: registered ack/err one cycle after wr_en; inj forces a rejection.
    assign fifo_full = (fcount == 8);

    always @(posedge clk) begin
        if (fifo_clr) begin
            fcount      <= 0;
            fifo_wr_ack <= 1'b0;
            fifo_wr_err <= 1'b0;
        end else begin
            fifo_wr_ack <= fifo_wr_en && !inj && (fcount < 8);
            fifo_wr_err <= fifo_wr_en && (inj || fcount >= 8);
            fcount      <= fcount + ((fifo_wr_en && !inj && fcount < 8) ? 1 : 0)
                                  - ((rd && fcount > 0) ? 1 : 0);
        end
    end

    function automatic int model_winner(logic [N-1:0] r, int ptr);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (r[k]) return k + 0 * ptr;
        end
`endif
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        req      = '0;
        rd       = 1'b0;
        inj      = 1'b0;
        reset_n  = 1'b0;
        fifo_clr = 1'b1;
        tick();
        reset_n  = 1'b1;
        fifo_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        #1;
        total++;
        if ({gnt, done, err, busy, fifo_wr_en} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0", {gnt, done, err, busy, fifo_wr_en});
        end
        req = '1;
        tick();
        tick();
        total++;
        if ({gnt, done, err, busy, fifo_wr_en} !== '0 || fifo_din !== '0) begin
            bad++;
            $display("FAIL reset_hold: ctrl %b din %h want 0", {gnt, done, err, busy, fifo_wr_en},
                     fifo_din);
        end
        restart();
    endtask

    task automatic test_single_write();
        restart();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom();
        req_data[0 +: DW] = 32'hA5A5_0001;
        req = 4'b0001;
        tick();
        req = '0;
        total++;
        if (fifo_wr_en !== 1'b1 || fifo_din !== 32'hA5A5_0001 || gnt !== 4'b0001 || busy !== 1'b1
            || done !== '0) begin
            bad++;
            $display("FAIL t1_write: wr_en %b din %h gnt %b busy %b done %b want 1 a5a50001 0001 1 0000",
                     fifo_wr_en, fifo_din, gnt, busy, done);
        end
        tick();
        total++;
        if (fifo_wr_en !== 1'b0 || done !== 4'b0001 || err !== '0 || gnt !== 4'b0001) begin
            bad++;
            $display("FAIL t1_done: wr_en %b done %b err %b gnt %b want 0 0001 0000 0001",
                     fifo_wr_en, done, err, gnt);
        end
        tick();
        total++;
        if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin
            bad++;
            $display("FAIL t1_idle: gnt %b busy %b done %b want 0", gnt, busy, done);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] e;
        restart();
`ifdef ARB_ROUND_ROBIN_EN
        req = 4'b1111;
`else
        req = 4'b1110;
`endif
        for (int k = 0; k < 5; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            e = N'(1) << (k % N);
`else
            e = 4'b0010;
`endif
            tick();
            total++;
            if (gnt !== e || fifo_wr_en !== 1'b1) begin
                bad++;
                $display("FAIL prio_grant%0d: gnt %b wr_en %b want %b 1", k, gnt, fifo_wr_en, e);
            end
            tick();
            total++;
            if (done !== e || fifo_wr_en !== 1'b0) begin
                bad++;
                $display("FAIL prio_done%0d: done %b wr_en %b want %b 0", k, done, fifo_wr_en, e);
            end
            tick();
            total++;
            if (gnt !== '0 || fifo_wr_en !== 1'b0) begin
                bad++;
                $display("FAIL prio_gap%0d: gnt %b wr_en %b want 0 0", k, gnt, fifo_wr_en);
            end
        end
        req = '0;
    endtask

    task automatic test_full();
        restart();
        req = 4'b0001;
        repeat (24) tick();
        req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (fifo_wr_en !== 1'b0 || gnt !== '0 || err !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL full_wait%0d: wr_en %b gnt %b err %b busy %b want all 0",
                         k, fifo_wr_en, gnt, err, busy);
            end
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        total++;
        if (gnt !== '0 || fifo_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL full_read: gnt %b wr_en %b want 0 0", gnt, fifo_wr_en);
        end
        tick();
        total++;
        if (gnt !== 4'b0100 || fifo_wr_en !== 1'b1) begin
            bad++;
            $display("FAIL full_resume: gnt %b wr_en %b want 0100 1", gnt, fifo_wr_en);
        end
        req = '0;
        tick();
        total++;
        if (done !== 4'b0100 || err !== '0) begin
            bad++;
            $display("FAIL full_done: done %b err %b want 0100 0000", done, err);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        restart();
        req = 4'b0011;
        tick();
        total++;
        if (fifo_wr_en !== 1'b1 || gnt !== 4'b0001) begin
            bad++;
            $display("FAIL t5_pre: wr_en %b gnt %b want 1 0001", fifo_wr_en, gnt);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({fifo_wr_en, gnt, done, err, busy} !== '0) begin
            bad++;
            $display("FAIL t5_async: ctrl %b want 0", {fifo_wr_en, gnt, done, err, busy});
        end
        tick();
        total++;
        if (done !== '0 || err !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL t5_held: done %b err %b busy %b want 0", done, err, busy);
        end
        reset_n = 1'b1;
        tick();
        // Pointer was cleared by reset, so requester 0 wins again.
        total++;
        if (gnt !== 4'b0001 || fifo_wr_en !== 1'b1) begin
            bad++;
            $display("FAIL t5_after: gnt %b wr_en %b want 0001 1", gnt, fifo_wr_en);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_dropped_req();
        restart();
        req = 4'b0010;
        tick();
        req = '0;
        total++;
        if (gnt !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_din !== req_data[1*DW +: DW]) begin
            bad++;
            $display("FAIL t6_write: gnt %b wr_en %b din %h want 0010 1 %h",
                     gnt, fifo_wr_en, fifo_din, req_data[1*DW +: DW]);
        end
        tick();
        total++;
        if (done !== 4'b0010) begin
            bad++;
            $display("FAIL t6_done: done %b want 0010", done);
        end
        tick();
        total++;
        if (done !== '0 || busy !== 1'b0 || gnt !== '0) begin
            bad++;
            $display("FAIL t6_once: done %b busy %b gnt %b want 0", done, busy, gnt);
        end
    endtask

    task automatic test_random();
        int free_at;
        int rr;
        int w;
        restart();
        free_at = 0;
        rr      = 0;
        for (int c = 0; c < L + 4; c++) begin
            eg[c] = '0; ed[c] = '0; ee[c] = '0; ew[c] = 1'b0; eb[c] = 1'b0; ex[c] = '0;
        end
        for (int c = 0; c < L; c++) begin
            total++;
            if (gnt !== eg[c] || done !== ed[c] || err !== ee[c] || fifo_wr_en !== ew[c]
                || busy !== eb[c] || (ew[c] && fifo_din !== ex[c])) begin
                bad++;
                $display("FAIL rand_c%0d: gnt %b done %b err %b wr_en %b busy %b din %h want %b %b %b %b %b %h",
                         c, gnt, done, err, fifo_wr_en, busy, fifo_din,
                         eg[c], ed[c], ee[c], ew[c], eb[c], ex[c]);
            end
            req = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom();
            rd = ($urandom_range(0, 3) == 0);
            if (c >= free_at && (|req) && !fifo_full) begin
                w         = model_winner(req, rr);
                inj       = ($urandom_range(0, 4) == 0);
                eg[c+1]   = N'(1) << w;
                ew[c+1]   = 1'b1;
                eb[c+1]   = 1'b1;
                ex[c+1]   = req_data[w*DW +: DW];
                eg[c+2]   = N'(1) << w;
                eb[c+2]   = 1'b1;
                ed[c+2]   = inj ? '0 : N'(1) << w;
                ee[c+2]   = inj ? N'(1) << w : '0;
                free_at   = c + 3;
                rr        = (w + 1) % N;
            end
            tick();
        end
        req = '0;
        rd  = 1'b0;
        inj = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_priority();
        test_full();
        test_reset_mid_op();
        test_dropped_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
